// File: rtl/axi_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axi_fifo_pkg
//   Shared types and constants for the async-FIFO read-side adapter.
//   - rd_adp_state_e : occupancy FSM of the 2-entry prefetch buffer. Each
//                      state's encoding equals the number of words it holds.
//   - STATS_CNT_W    : width of the optional delivered-beat counter.
//   - occ_of()       : state -> occupancy (0..2).
// -----------------------------------------------------------------------------
package axi_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_adp_state_e;

    localparam int STATS_CNT_W = 32;

    function automatic logic [1:0] occ_of(input rd_adp_state_e s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_fifo_rd_adapter.sv
// -----------------------------------------------------------------------------
// axi_fifo_rd_adapter
//   Converts the async FIFO's read interface (rd_en / empty / rd_data that is
//   registered and returned one cycle after rd_en) into a valid/ready stream.
//   A 2-entry prefetch buffer (head + tail) sustains one beat per cycle and
//   never drops or duplicates a word under backpressure.
//
//   Optional feature: define AXI_FIFO_RD_ADAPTER_STATS_EN to build a 32-bit
//   wrapping count of delivered beats on beat_cnt_o; otherwise the port is
//   tied to zero. The port list is the same in both builds.
//
// Ports
//   m_clk_i         in   FIFO read-domain clock
//   m_rst_ni        in   asynchronous active-low reset (shared with the FIFO)
//   fifo_empty_i    in   FIFO empty flag
//   fifo_rd_data_i  in   FIFO read data, valid the cycle after an issued rd_en
//   fifo_rd_en_o    out  FIFO read enable
//   m_valid_o       out  output beat valid
//   m_ready_i       in   downstream ready
//   m_data_o        out  output payload (head entry)
//   beat_cnt_o      out  delivered-beat count (0 unless stats are built)
// -----------------------------------------------------------------------------
module axi_fifo_rd_adapter
    import axi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                   m_clk_i,
    input  logic                   m_rst_ni,
    input  logic                   fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data_i,
    output logic                   fifo_rd_en_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DATA_WIDTH-1:0]  m_data_o,
    output logic [STATS_CNT_W-1:0] beat_cnt_o
);

    rd_adp_state_e          r_state;
    rd_adp_state_e          w_state_nxt;
    logic                   r_inflight;   // a read was issued last cycle
    logic                   r_rst_done;   // low until the first edge after reset
    logic [DATA_WIDTH-1:0]  r_head;
    logic [DATA_WIDTH-1:0]  r_tail;

    logic                   w_pop;
    logic                   w_arr;
    logic [2:0]             w_level;      // words held plus word in flight
    logic                   w_post_zero;  // buffer is empty once this cycle's pop is taken

    assign w_arr = r_inflight;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of the order blocks are evaluated.
    always_ff @(posedge m_clk_i or negedge m_rst_ni) begin
        if (!m_rst_ni) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_arr) w_state_nxt = ONE;
            ONE: begin
                if (w_pop && !w_arr)      w_state_nxt = EMPTY;
                else if (!w_pop && w_arr) w_state_nxt = TWO;
            end
            // pop & arr keeps TWO; !pop & arr cannot happen (issue rule).
            TWO:     if (w_pop && !w_arr) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // m_ready_i reaches fifo_rd_en_o combinationally on purpose: a slot freed by
    // this cycle's pop is refilled in the same cycle, which is what sustains one
    // beat per cycle with only two entries.
    always_comb begin
        m_valid_o    = (r_state != EMPTY);
        m_data_o     = r_head;
        w_pop        = m_valid_o && m_ready_i;
        w_level      = {1'b0, occ_of(r_state)} + {2'b00, r_inflight};
        // occ + inflight - pop < 2, rearranged to avoid a subtraction.
        fifo_rd_en_o = r_rst_done && !fifo_empty_i
                       && (w_level < (3'd2 + {2'b00, w_pop}));
    end

    // -------------------------------------------------------------------------
    // Prefetch buffer and read tracking
    // -------------------------------------------------------------------------
    assign w_post_zero = (r_state == EMPTY) || ((r_state == ONE) && w_pop);

    // NOTE: head/tail are reset (unusual for a datapath) because m_data_o must
    // read 0 out of reset.
    always_ff @(posedge m_clk_i or negedge m_rst_ni) begin
        if (!m_rst_ni) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_inflight <= 1'b0;   // a word in flight at reset is discarded
            r_rst_done <= 1'b0;
        end else begin
            // Delays the first read by one edge after release, so rd_en is never
            // asserted while reset is still being deasserted.
            r_rst_done <= 1'b1;
            r_inflight <= fifo_rd_en_o;

            // Pop from TWO promotes the tail; an arrival in the same cycle goes
            // to the tail behind it, so order is preserved.
            if (w_pop && (r_state == TWO)) begin
                r_head <= r_tail;
            end
            if (w_arr) begin
                if (w_post_zero) r_head <= fifo_rd_data_i;
                else             r_tail <= fifo_rd_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    // An arrival into a full buffer with no pop would lose a word.
    a_no_overflow: assert property (@(posedge m_clk_i) disable iff (!m_rst_ni)
        !((r_state == TWO) && !w_pop && r_inflight));
`endif

    // -------------------------------------------------------------------------
    // Optional delivered-beat counter
    // -------------------------------------------------------------------------
`ifdef AXI_FIFO_RD_ADAPTER_STATS_EN
    logic [STATS_CNT_W-1:0] r_beat_cnt;

    always_ff @(posedge m_clk_i or negedge m_rst_ni) begin
        if (!m_rst_ni) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + STATS_CNT_W'(1);   // wraps naturally
        end
    end

    assign beat_cnt_o = r_beat_cnt;
`else
    assign beat_cnt_o = '0;
`endif

endmodule
